// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ read requesters onto one SDRAM read
// controller, with done-edge detection, a per-transaction timeout and a wait-for-done-low phase.
module sdram_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      err_timeout,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ctl_address,
  output logic                      ctl_read_enable,
  input  logic [DATA_W-1:0]         ctl_data_out,
  input  logic                      ctl_read_done
);

  localparam int          PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, WAIT_LOW} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rden_q, rden_d;
  logic                done_prev_q;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    scan_idx;
  logic [PTR_W-1:0]    owner_inc;
  logic [15:0]         cnt_inc;
  logic                done_rise;

  // Scan starting at ptr and wrapping, so the most recently served requester goes last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign owner_inc = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign cnt_inc   = cnt_q + 16'd1;
  assign done_rise = ctl_read_done & ~done_prev_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    err_d      = 1'b0;
    addr_d     = addr_q;
    rden_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          addr_d           = req_addr[win_idx*ADDR_W +: ADDR_W];
          owner_d          = win_idx;
          gnt_d[win_idx]   = 1'b1;
          rden_d           = 1'b1;
          cnt_d            = '0;
          state_d          = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_inc;
        // A completion edge wins over a timeout landing on the same cycle.
        if (done_rise) begin
          rd_data_d           = ctl_data_out;
          rd_valid_d[owner_q] = 1'b1;
          ptr_d               = owner_inc;
          state_d             = WAIT_LOW;
        end else if (cnt_inc == TIMEOUT_C) begin
          err_d   = 1'b1;
          ptr_d   = owner_inc;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ctl_read_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      rden_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      rden_q      <= rden_d;
      done_prev_q <= ctl_read_done;
    end
  end

  assign gnt             = gnt_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign err_timeout     = err_q;
  assign busy            = (state_q != IDLE);
  assign ctl_address     = addr_q;
  assign ctl_read_enable = rden_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Scoreboard bench for sdram_read_arbiter: directed requests push expected grants and
// completions into queues, a negedge monitor pops and compares whenever the DUT pulses.
module tb_sdram_read_arbiter;

  localparam int NR = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   rd_valid;
  logic [DW-1:0]   rd_data;
  logic            err_timeout;
  logic            busy;
  logic [AW-1:0]   ctl_address;
  logic            ctl_read_enable;
  logic [DW-1:0]   ctl_data_out;
  logic            ctl_read_done;

  sdram_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .req_addr        (req_addr),
    .gnt             (gnt),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .err_timeout     (err_timeout),
    .busy            (busy),
    .ctl_address     (ctl_address),
    .ctl_read_enable (ctl_read_enable),
    .ctl_data_out    (ctl_data_out),
    .ctl_read_done   (ctl_read_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [AW-1:0] addr;
  } gexp_t;

  typedef struct packed {
    logic          to;
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
  } cexp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  gexp_t g_pop;
  cexp_t c_pop;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_gnt_cyc = 0;
  logic [DW-1:0] last_data;
  logic done_s;

  logic hold_req;
  logic ctl_never;
  int   ctl_delay;
  int   ctl_hold;
  logic [DW-1:0] key;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic hold);
    hold_req = hold;
    req      = r;
  endtask

  task automatic setAddr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic expectGnt(input logic [NR-1:0] g, input logic [AW-1:0] a);
    gexp_t e;
    e.gnt  = g;
    e.addr = a;
    gq.push_back(e);
  endtask

  task automatic expectCpl(input logic to, input logic [NR-1:0] v, input logic [DW-1:0] d);
    cexp_t e;
    e.to   = to;
    e.vld  = v;
    e.data = d;
    cq.push_back(e);
  endtask

  task automatic checkZeroOutputs();
    checkOutput("rst_gnt", 32'(gnt), 0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 0);
    checkOutput("rst_rd_data", 32'(rd_data), 0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ctl_address", 32'(ctl_address), 0);
    checkOutput("rst_ctl_read_enable", 32'(ctl_read_enable), 0);
  endtask

  task automatic doReset();
    reset_n  = 1'b0;
    req      = '0;
    hold_req = 1'b0;
    gq.delete();
    cq.delete();
    last_data = '0;
    repeat (2) @(negedge clk);
    checkZeroOutputs();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (gq.size() == 0 && cq.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drain_pending", 32'(gq.size() + cq.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  // Requesters drop their line once they see their grant unless told to hold it.
  always @(negedge clk) begin
    if (!hold_req) req = req & ~gnt;
  end

  // Controller model: answers each read start after ctl_delay cycles, holds done for ctl_hold.
  always begin
    @(negedge clk);
    if (reset_n && ctl_read_enable && !ctl_never) begin
      repeat (ctl_delay) @(negedge clk);
      ctl_data_out  = ctl_address[DW-1:0] ^ key;
      ctl_read_done = 1'b1;
      repeat (ctl_hold) @(negedge clk);
      ctl_read_done = 1'b0;
    end
  end

  always @(posedge clk) done_s <= ctl_read_done;

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (gnt != '0 || ctl_read_enable) begin
        if (gq.size() == 0) begin
          checkOutput("gnt_unexpected", {27'd0, ctl_read_enable, gnt}, 0);
        end else begin
          g_pop = gq.pop_front();
          checkOutput("gnt", 32'(gnt), 32'(g_pop.gnt));
          checkOutput("ctl_read_enable", 32'(ctl_read_enable), 1);
          checkOutput("ctl_address", 32'(ctl_address), 32'(g_pop.addr));
          checkOutput("rden_while_done_high", 32'(done_s), 0);
          last_gnt_cyc = cyc;
        end
      end
      if (rd_valid != '0 || err_timeout) begin
        if (cq.size() == 0) begin
          checkOutput("cpl_unexpected", {27'd0, err_timeout, rd_valid}, 0);
        end else begin
          c_pop = cq.pop_front();
          checkOutput("err_timeout", 32'(err_timeout), 32'(c_pop.to));
          if (c_pop.to) begin
            checkOutput("rd_valid_on_timeout", 32'(rd_valid), 0);
            checkOutput("rd_data_kept", 32'(rd_data), 32'(last_data));
            checkOutput("timeout_latency", 32'(cyc - last_gnt_cyc), 32'(TO));
          end else begin
            checkOutput("rd_valid", 32'(rd_valid), 32'(c_pop.vld));
            checkOutput("rd_data", 32'(rd_data), 32'(c_pop.data));
            last_data = c_pop.data;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset_n       = 1'b0;
    req           = '0;
    req_addr      = '0;
    hold_req      = 1'b0;
    ctl_never     = 1'b0;
    ctl_delay     = 2;
    ctl_hold      = 1;
    key           = '0;
    ctl_data_out  = '0;
    ctl_read_done = 1'b0;
    last_data     = '0;
    @(negedge clk);
    doReset();

    $display("[TB] single request");
    key = 16'h8AB9;
    setAddr(0, 25'h0123456);
    expectGnt(4'b0001, 25'h0123456);
    expectCpl(1'b0, 4'b0001, 16'hBEEF);
    applyStimulus(4'b0001, 1'b0);
    @(negedge clk);
    checkOutput("gnt_latency", 32'(gnt), 32'h1);
    checkOutput("busy_active", 32'(busy), 1);
    waitDrain(50);

    $display("[TB] round robin with held requests");
    doReset();
    key = '0;
    for (int i = 0; i < NR; i++) setAddr(i, 25'h0AB0000 | AW'(16'h1000 + i * 16'h0111));
    expectGnt(4'b0001, 25'h0AB1000); expectCpl(1'b0, 4'b0001, 16'h1000);
    expectGnt(4'b0010, 25'h0AB1111); expectCpl(1'b0, 4'b0010, 16'h1111);
    expectGnt(4'b0100, 25'h0AB1222); expectCpl(1'b0, 4'b0100, 16'h1222);
    expectGnt(4'b1000, 25'h0AB1333); expectCpl(1'b0, 4'b1000, 16'h1333);
    expectGnt(4'b0001, 25'h0AB1000); expectCpl(1'b0, 4'b0001, 16'h1000);
    applyStimulus(4'b1111, 1'b1);
    n = 0;
    for (int i = 0; i < 300 && n < 5; i++) begin
      @(negedge clk);
      if (gnt != '0) n++;
    end
    applyStimulus(4'b0000, 1'b0);
    checkOutput("rr_grant_count", 32'(n), 5);
    waitDrain(100);

    $display("[TB] multi-cycle done");
    doReset();
    ctl_delay = 1;
    ctl_hold  = 3;
    setAddr(0, 25'h0002222);
    setAddr(1, 25'h0003333);
    expectGnt(4'b0001, 25'h0002222); expectCpl(1'b0, 4'b0001, 16'h2222);
    expectGnt(4'b0010, 25'h0003333); expectCpl(1'b0, 4'b0010, 16'h3333);
    applyStimulus(4'b0011, 1'b0);
    waitDrain(100);

    $display("[TB] timeout");
    doReset();
    ctl_never = 1'b1;
    setAddr(2, 25'h1555555);
    expectGnt(4'b0100, 25'h1555555);
    expectCpl(1'b1, 4'b0000, 16'h0000);
    applyStimulus(4'b0100, 1'b0);
    waitDrain(100);
    checkOutput("busy_after_timeout", 32'(busy), 0);
    ctl_never = 1'b0;
    ctl_delay = 1;
    ctl_hold  = 1;
    setAddr(3, 25'h0004444);
    setAddr(0, 25'h0005555);
    expectGnt(4'b1000, 25'h0004444); expectCpl(1'b0, 4'b1000, 16'h4444);
    expectGnt(4'b0001, 25'h0005555); expectCpl(1'b0, 4'b0001, 16'h5555);
    applyStimulus(4'b1001, 1'b0);
    waitDrain(100);

    $display("[TB] done edge coincident with timeout");
    ctl_delay = TO - 1;
    setAddr(1, 25'h0006666);
    expectGnt(4'b0010, 25'h0006666);
    expectCpl(1'b0, 4'b0010, 16'h6666);
    applyStimulus(4'b0010, 1'b0);
    waitDrain(100);

    $display("[TB] reset in the middle of a read");
    ctl_never = 1'b1;
    setAddr(0, 25'h0ABCDEF);
    expectGnt(4'b0001, 25'h0ABCDEF);
    applyStimulus(4'b0001, 1'b0);
    waitDrain(50);
    checkOutput("busy_before_reset", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkZeroOutputs();
    @(negedge clk);
    reset_n   = 1'b1;
    last_data = '0;
    ctl_never = 1'b0;
    repeat (TO + 4) @(negedge clk);
    setAddr(1, 25'h0007777);
    setAddr(3, 25'h0008888);
    expectGnt(4'b0010, 25'h0007777); expectCpl(1'b0, 4'b0010, 16'h7777);
    expectGnt(4'b1000, 25'h0008888); expectCpl(1'b0, 4'b1000, 16'h8888);
    applyStimulus(4'b1010, 1'b0);
    waitDrain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_read_arbiter.md
SDRAM_READ_ARBITER -- requirements
Module: sdram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 25, SDRAM word address width.
REQ-003 Parameter DATA_W, default 16, read data width.
REQ-004 Parameter TIMEOUT, default 255, maximum WAIT_DONE cycles before abort (1..65535).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NUM_REQ  per-requester read request level; held until that requester's gnt bit is seen.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W], stable while req[i] is high.
REQ-010 gnt  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-011 rd_valid  output  NUM_REQ  one-hot, one-cycle read-complete pulse.
REQ-012 rd_data  output  DATA_W  read data, valid while any rd_valid bit is high, held otherwise.
REQ-013 err_timeout  output  1  one-cycle pulse on transaction abort.
REQ-014 busy  output  1  high whenever state is not IDLE (combinational from state).
REQ-015 ctl_address  output  ADDR_W  address to the SDRAM read controller.
REQ-016 ctl_read_enable  output  1  one-cycle read start pulse to the controller.
REQ-017 ctl_data_out  input  DATA_W  controller read data.
REQ-018 ctl_read_done  input  1  controller completion flag; may stay high for several cycles.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, WAIT_DONE and WAIT_LOW.
REQ-020 IDLE with req != 0 SHALL select a winner by round-robin from pointer ptr: first set bit at index ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-021 On that edge the block SHALL register ctl_address <= winner's req_addr, owner <= winner, gnt[winner] <= 1 and ctl_read_enable <= 1, and enter WAIT_DONE.
REQ-022 The gnt and ctl_read_enable pulses SHALL be high for exactly one cycle, coincident, one cycle after req is sampled.
REQ-023 IDLE with req == 0 SHALL remain in IDLE with all pulse outputs low.
REQ-024 While not in IDLE, req SHALL be ignored; requests arriving then wait without loss.
REQ-025 WAIT_DONE SHALL detect a rising edge of ctl_read_done (current 1, previous-cycle registered 0), never a level.
REQ-026 On that edge: rd_data <= ctl_data_out, rd_valid[owner] <= 1 for one cycle, ptr <= (owner+1) mod NUM_REQ, next state WAIT_LOW.
REQ-027 The WAIT_DONE cycle counter SHALL clear on entry and increment each cycle in WAIT_DONE.
REQ-028 If the counter reaches TIMEOUT without a done edge: err_timeout pulse for one cycle, no rd_valid, rd_data unchanged, ptr <= (owner+1) mod NUM_REQ, next state WAIT_LOW.
REQ-029 If the done edge and TIMEOUT occur on the same cycle, completion SHALL take priority and err_timeout SHALL stay low.
REQ-030 WAIT_LOW SHALL return to IDLE on the first cycle ctl_read_done is 0, so no new read is issued while done is still high.
REQ-031 ctl_address SHALL hold its last value outside the issue edge.
REQ-032 At most one gnt bit and at most one rd_valid bit SHALL be high on any cycle.

Reset
REQ-033 reset_n low SHALL asynchronously force state=IDLE, ptr=0, owner=0, counter=0, gnt=0, rd_valid=0, rd_data=0, err_timeout=0, ctl_address=0, ctl_read_enable=0 and the done-edge register=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no rd_valid or err_timeout pulse; after release, arbitration SHALL restart with requester 0 highest priority.

Verification
REQ-035 Single request: req=0001, req_addr[0]=0x0123456 -> next cycle gnt=0001, ctl_read_enable=1, ctl_address=0x0123456; controller model returns 0xBEEF -> rd_valid=0001 with rd_data=0xBEEF for one cycle.
REQ-036 Round-robin: req=1111 held high through four transactions from reset -> gnt order 0001, 0010, 0100, 1000, then 0001.
REQ-037 Multi-cycle done: ctl_read_done held high for 3 cycles -> exactly one rd_valid pulse, and no ctl_read_enable until one cycle after done falls.
REQ-038 Timeout: TIMEOUT=8, controller never raises done -> err_timeout pulses on the 8th WAIT_DONE cycle, rd_valid stays 0, busy falls, next grant goes to owner+1.
REQ-039 Reset mid-operation: reset_n pulsed low in WAIT_DONE -> all outputs 0 immediately, no rd_valid afterwards, next grant from req=1010 is 0010.
REQ-040 Coincidence: done edge on the cycle the counter reaches TIMEOUT -> rd_valid pulses and err_timeout stays 0.
